// File: rtl/conv2d_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between two conv2D requesters.
// An in-order 1-bit tag FIFO records the owner of each outstanding read so that responses route back.
module conv2d_mem_arbiter #(
  parameter int DWIDTH          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       r0_req_addr,
  input  logic                              r0_req_valid,
  output logic                              r0_req_ready,
  input  logic [DWIDTH-1:0]                 r0_req_data,
  input  logic                              r0_req_write,
  output logic [DWIDTH-1:0]                 r0_resp_data,
  output logic                              r0_resp_valid,
  input  logic                              r0_resp_ready,
  input  logic [31:0]                       r1_req_addr,
  input  logic                              r1_req_valid,
  output logic                              r1_req_ready,
  input  logic [DWIDTH-1:0]                 r1_req_data,
  input  logic                              r1_req_write,
  output logic [DWIDTH-1:0]                 r1_resp_data,
  output logic                              r1_resp_valid,
  input  logic                              r1_resp_ready,
  output logic [31:0]                       mem_req_addr,
  output logic [DWIDTH-1:0]                 mem_req_data,
  output logic                              mem_req_write,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  input  logic [DWIDTH-1:0]                 mem_resp_data,
  input  logic                              mem_resp_valid,
  output logic                              mem_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              idle,
  output logic                              err
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

  logic                       last_q, last_d, lock_q, lock_d, lock_id_q, lock_id_d, err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;
  logic cand_s, cand_valid_s, cand_write_s, can_issue_s, hs_s, push_s, pop_s, nonempty_s, head_tag_s;

  // A stalled grant stays locked so memory sees stable request fields until it is accepted.
  always_comb begin
    cand_s       = 1'b0;
    cand_valid_s = 1'b0;
    if (lock_q) begin
      cand_s       = lock_id_q;
      cand_valid_s = lock_id_q ? r1_req_valid : r0_req_valid;
    end else if (r0_req_valid && r1_req_valid) begin
      cand_s       = ~last_q;
      cand_valid_s = 1'b1;
    end else if (r1_req_valid) begin
      cand_s       = 1'b1;
      cand_valid_s = 1'b1;
    end else begin
      cand_s       = 1'b0;
      cand_valid_s = r0_req_valid;
    end
  end

  assign cand_write_s  = cand_s ? r1_req_write : r0_req_write;
  assign can_issue_s   = cand_valid_s & (cand_write_s | (count_q != FULL));
  assign mem_req_valid = can_issue_s;
  assign mem_req_addr  = cand_s ? r1_req_addr : r0_req_addr;
  assign mem_req_data  = cand_s ? r1_req_data : r0_req_data;
  assign mem_req_write = cand_write_s;
  assign r0_req_ready  = mem_req_ready & can_issue_s & ~cand_s;
  assign r1_req_ready  = mem_req_ready & can_issue_s & cand_s;
  assign hs_s          = can_issue_s & mem_req_ready;
  assign push_s        = hs_s & ~cand_write_s;

  // With no read in flight a response is an orphan: swallow it and flag it.
  assign nonempty_s     = (count_q != '0);
  assign head_tag_s     = tag_q[head_q];
  assign mem_resp_ready = nonempty_s ? (head_tag_s ? r1_resp_ready : r0_resp_ready) : 1'b1;
  assign r0_resp_valid  = mem_resp_valid & nonempty_s & ~head_tag_s;
  assign r1_resp_valid  = mem_resp_valid & nonempty_s & head_tag_s;
  assign r0_resp_data   = mem_resp_data;
  assign r1_resp_data   = mem_resp_data;
  assign pop_s          = mem_resp_valid & mem_resp_ready & nonempty_s;
  assign outstanding    = count_q;
  assign idle           = (count_q == '0) & ~can_issue_s;
  assign err            = err_q;

  // Next-state for grant history, lock, tag FIFO and error flag.
  always_comb begin
    last_d    = hs_s ? cand_s : last_q;
    lock_d    = can_issue_s & ~mem_req_ready;
    lock_id_d = lock_d ? cand_s : lock_id_q;
    tag_d     = tag_q;
    if (push_s) begin
      tag_d[tail_q] = cand_s;
    end else begin
      tag_d = tag_q;
    end
    tail_d = push_s ? tail_q + PW'(1) : tail_q;
    head_d = pop_s ? head_q + PW'(1) : head_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (mem_resp_valid & ~nonempty_s);
  end

  // State registers; last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
      tag_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      last_q    <= last_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      tag_q     <= tag_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_conv2d_mem_arbiter.sv
// Scoreboard bench for conv2d_mem_arbiter: expected grants and response owners are queued as
// stimulus is driven and popped when the arbiter hands off a request or routes a response.
module tb_conv2d_mem_arbiter;
  logic        clk, rst;
  logic [31:0] r0_req_addr, r1_req_addr, r0_req_data, r1_req_data;
  logic        r0_req_valid, r1_req_valid, r0_req_write, r1_req_write;
  logic        r0_req_ready, r1_req_ready;
  logic [31:0] r0_resp_data, r1_resp_data;
  logic        r0_resp_valid, r1_resp_valid, r0_resp_ready, r1_resp_ready;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  logic        mem_req_write, mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  logic [2:0]  outstanding;
  logic        idle, err;

  typedef struct {bit id; logic [31:0] addr; logic [31:0] data; bit wr;} req_t;
  req_t exp_req_q[$];
  bit   exp_tag_q[$];
  int   errors = 0;
  int   checks = 0;

  conv2d_mem_arbiter #(.DWIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req_addr(r0_req_addr), .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_data(r0_req_data), .r0_req_write(r0_req_write), .r0_resp_data(r0_resp_data),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r1_req_addr(r1_req_addr), .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_data(r1_req_data), .r1_req_write(r1_req_write), .r1_resp_data(r1_resp_data),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .outstanding(outstanding), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    r0_req_valid = 1'b0; r1_req_valid = 1'b0; r0_req_write = 1'b0; r1_req_write = 1'b0;
    r0_req_addr = 32'h0; r1_req_addr = 32'h0; r0_req_data = 32'h0; r1_req_data = 32'h0;
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
  endtask

  // Drive a single requester until its request is handed to memory.
  task automatic issue_one(input bit id, input logic [31:0] addr, input bit wr, input logic [31:0] data);
    req_t e;
    exp_req_q.push_back('{id: id, addr: addr, data: data, wr: wr});
    if (!wr) exp_tag_q.push_back(id);
    if (id) begin
      r1_req_valid = 1'b1; r1_req_addr = addr; r1_req_write = wr; r1_req_data = data;
    end else begin
      r0_req_valid = 1'b1; r0_req_addr = addr; r0_req_write = wr; r0_req_data = data;
    end
    mem_req_ready = 1'b1;
    #1;
    e = exp_req_q.pop_front();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== e.addr || mem_req_write !== e.wr ||
        (e.wr && mem_req_data !== e.data))
      begin errors++; $display("FAIL issue_fields: valid=%b addr=%h wr=%b data=%h, required 1 %h %b %h",
        mem_req_valid, mem_req_addr, mem_req_write, mem_req_data, e.addr, e.wr, e.data); end
    checks++;
    if (r0_req_ready !== !e.id || r1_req_ready !== e.id)
      begin errors++; $display("FAIL issue_ready: r0=%b r1=%b, required grant to %0d", r0_req_ready, r1_req_ready, e.id); end
    @(posedge clk); #1;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
  endtask

  // Return one memory response per queued tag; data = base + k*step.
  task automatic drain_resp(input logic [31:0] base, input logic [31:0] step);
    bit rid;
    logic [31:0] d;
    int k = 0;
    while (exp_tag_q.size() != 0) begin
      rid = exp_tag_q.pop_front();
      d = base + step * 32'(k);
      k++;
      mem_resp_valid = 1'b1; mem_resp_data = d;
      #1;
      checks++;
      if (r0_resp_valid !== !rid || r1_resp_valid !== rid || mem_resp_ready !== 1'b1)
        begin errors++; $display("FAIL resp_route: r0_v=%b r1_v=%b mrdy=%b, required owner %0d", r0_resp_valid, r1_resp_valid, mem_resp_ready, rid); end
      checks++;
      if ((rid ? r1_resp_data : r0_resp_data) !== d)
        begin errors++; $display("FAIL resp_data: got %h, required %h", rid ? r1_resp_data : r0_resp_data, d); end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0)
      begin errors++; $display("FAIL drain_outstanding: got %0d, required 0", outstanding); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || idle !== 1'b1 || err !== 1'b0 || mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b1)
      begin errors++; $display("FAIL reset_state: out=%0d idle=%b err=%b mvalid=%b mrdy=%b, required 0 1 0 0 1",
        outstanding, idle, err, mem_req_valid, mem_resp_ready); end
  endtask

  task automatic test_round_robin();
    req_t e;
    exp_req_q.push_back('{id: 1'b0, addr: 32'h100, data: 32'h0, wr: 1'b0});
    exp_req_q.push_back('{id: 1'b1, addr: 32'h200, data: 32'h0, wr: 1'b0});
    exp_req_q.push_back('{id: 1'b0, addr: 32'h104, data: 32'h0, wr: 1'b0});
    exp_tag_q.push_back(1'b0); exp_tag_q.push_back(1'b1); exp_tag_q.push_back(1'b0);
    r0_req_valid = 1'b1; r0_req_addr = 32'h100; r1_req_valid = 1'b1; r1_req_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      e = exp_req_q.pop_front();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== e.addr)
        begin errors++; $display("FAIL rr_addr: cycle %0d valid=%b addr=%h, required 1 %h", c, mem_req_valid, mem_req_addr, e.addr); end
      checks++;
      if (r0_req_ready !== !e.id || r1_req_ready !== e.id)
        begin errors++; $display("FAIL rr_grant: cycle %0d r0=%b r1=%b, required grant to %0d", c, r0_req_ready, r1_req_ready, e.id); end
      @(posedge clk); #1;
      if (c == 0) r0_req_addr = 32'h104;
      if (c == 1) r1_req_valid = 1'b0;
      if (c == 2) r0_req_valid = 1'b0;
    end
    #1;
    checks++;
    if (outstanding !== 3'd3)
      begin errors++; $display("FAIL rr_outstanding: got %0d, required 3", outstanding); end
    drain_resp(32'hAAAA, 32'h1111);
    checks++;
    if (idle !== 1'b1)
      begin errors++; $display("FAIL rr_idle: got %b, required 1", idle); end
  endtask

  task automatic test_stall();
    r0_req_valid = 1'b1; r0_req_addr = 32'h300; r0_req_write = 1'b0;
    mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin r1_req_valid = 1'b1; r1_req_addr = 32'h400; r1_req_write = 1'b0; end
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300 || r0_req_ready !== 1'b0 || r1_req_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold: cycle %0d valid=%b addr=%h r0=%b r1=%b, required 1 300 0 0",
          c, mem_req_valid, mem_req_addr, r0_req_ready, r1_req_ready); end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_addr !== 32'h300 || r0_req_ready !== 1'b1 || r1_req_ready !== 1'b0)
      begin errors++; $display("FAIL stall_release: addr=%h r0=%b r1=%b, required 300 1 0", mem_req_addr, r0_req_ready, r1_req_ready); end
    exp_tag_q.push_back(1'b0);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_addr !== 32'h400 || r1_req_ready !== 1'b1 || r0_req_ready !== 1'b0)
      begin errors++; $display("FAIL stall_next: addr=%h r0=%b r1=%b, required 400 0 1", mem_req_addr, r0_req_ready, r1_req_ready); end
    exp_tag_q.push_back(1'b1);
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    drain_resp(32'h1111, 32'h1111);
  endtask

  task automatic test_fifo_full();
    bit rid;
    for (int i = 0; i < 4; i++) issue_one(1'b0, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    r0_req_valid = 1'b1; r0_req_addr = 32'h1010; r0_req_write = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || r0_req_ready !== 1'b0 || outstanding !== 3'd4)
      begin errors++; $display("FAIL full_block: valid=%b r0=%b out=%0d, required 0 0 4", mem_req_valid, r0_req_ready, outstanding); end
    @(posedge clk); #1;
    rid = exp_tag_q.pop_front();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hC000;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || r0_resp_valid !== !rid || r0_resp_data !== 32'hC000)
      begin errors++; $display("FAIL full_pop_same_cycle: mvalid=%b r0_v=%b data=%h, required 0 1 c000", mem_req_valid, r0_resp_valid, r0_resp_data); end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1010 || r0_req_ready !== 1'b1)
      begin errors++; $display("FAIL full_fifth: valid=%b addr=%h r0=%b, required 1 1010 1", mem_req_valid, mem_req_addr, r0_req_ready); end
    exp_tag_q.push_back(1'b0);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd4)
      begin errors++; $display("FAIL full_refill: got %0d, required 4", outstanding); end
    drain_resp(32'hC100, 32'h1);
  endtask

  task automatic test_write_interleave();
    issue_one(1'b0, 32'h500, 1'b0, 32'h0);
    issue_one(1'b1, 32'h600, 1'b1, 32'hDEADBEEF);
    issue_one(1'b0, 32'h504, 1'b0, 32'h0);
    #1;
    checks++;
    if (outstanding !== 3'd2)
      begin errors++; $display("FAIL write_no_tag: outstanding %0d, required 2", outstanding); end
    drain_resp(32'h5000, 32'h1);
  endtask

  task automatic test_resp_backpressure();
    issue_one(1'b1, 32'h700, 1'b0, 32'h0);
    r1_resp_ready = 1'b0; r0_resp_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (mem_resp_ready !== 1'b0 || r1_resp_valid !== 1'b1 || r0_resp_valid !== 1'b0)
        begin errors++; $display("FAIL bp_hold: cycle %0d mrdy=%b r1_v=%b r0_v=%b, required 0 1 0", c, mem_resp_ready, r1_resp_valid, r0_resp_valid); end
      @(posedge clk); #1;
    end
    checks++;
    if (outstanding !== 3'd1)
      begin errors++; $display("FAIL bp_count: got %0d, required 1", outstanding); end
    r1_resp_ready = 1'b1;
    drain_resp(32'h7777, 32'h0);
  endtask

  task automatic test_orphan();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1 || r0_resp_valid !== 1'b0 || r1_resp_valid !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL orphan_accept: mrdy=%b r0_v=%b r1_v=%b err=%b, required 1 0 0 0", mem_resp_ready, r0_resp_valid, r1_resp_valid, err); end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1)
      begin errors++; $display("FAIL orphan_sticky: err=%b, required 1", err); end
    issue_one(1'b0, 32'h800, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_tag_q.delete();
    #1;
    checks++;
    if (err !== 1'b0 || outstanding !== 3'd0)
      begin errors++; $display("FAIL midreset_clear: err=%b out=%0d, required 0 0", err, outstanding); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0800;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1 || r0_resp_valid !== 1'b0)
      begin errors++; $display("FAIL midreset_resp: mrdy=%b r0_v=%b, required 1 0", mem_resp_ready, r0_resp_valid); end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1)
      begin errors++; $display("FAIL midreset_err: err=%b, required 1", err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_write_interleave();
    test_resp_backpressure();
    test_orphan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
